// File: rtl/gbuf_b_pkg.sv
// Shared constants for Global Buffer B: geometry, counter widths and reader FSM encoding.
package gbuf_b_pkg;

    localparam int unsigned ADDR_WIDTH     = 6;
    localparam int unsigned BUF_NUM        = 16;
    localparam int unsigned OUT_DATA_WD    = 32;
    localparam int unsigned BRAM_DATA_WD   = 128;
    localparam int unsigned WORDS_PER_BANK = 32;
    localparam int unsigned LANES          = 4;

    localparam int unsigned LANE_W = $clog2(LANES);
    localparam int unsigned BANK_W = $clog2(BUF_NUM);
    localparam int unsigned WORD_W = $clog2(WORDS_PER_BANK);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_LAT  = 3'd2;
    localparam logic [2:0] ST_SER  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

endpackage

// File: rtl/gbuf_b_lane_ser.sv
// 128-to-32 lane serializer: a load strobe captures a word, lanes 0..3 leave over valid/ready.
module gbuf_b_lane_ser
    import gbuf_b_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic [BRAM_DATA_WD-1:0] word_i,
    input  logic                    ready_i,
    output logic [OUT_DATA_WD-1:0]  data_o,
    output logic                    valid_o,
    output logic                    last_c,
    output logic                    xfer_c
);

    logic [BRAM_DATA_WD-1:0] word_q, word_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [OUT_DATA_WD-1:0]  data_q, data_d;
    logic                    valid_q, valid_d;

    assign xfer_c  = valid_q & ready_i;
    assign last_c  = (lane_q == LANE_W'(LANES - 1));
    assign data_o  = data_q;
    assign valid_o = valid_q;

    // A load wins over a same-cycle transfer so back-to-back words leave no bubble.
    always_comb begin
        word_d  = word_q;
        lane_d  = lane_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (load_i) begin
            word_d  = word_i;
            lane_d  = '0;
            data_d  = word_i[OUT_DATA_WD-1:0];
            valid_d = 1'b1;
        end else if (xfer_c) begin
            lane_d = lane_q + LANE_W'(1);
            data_d = word_q[lane_d*OUT_DATA_WD +: OUT_DATA_WD];
            if (last_c) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= '0;
            lane_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            word_q  <= word_d;
            lane_q  <= lane_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/gbuf_b_reader.sv
// Read-side DMA for Global Buffer B: drains one ping-pong half, bank by bank, as a 32-bit stream.
// Optional GBUF_RD_PREFETCH_EN overlaps the next word's BRAM read with serialization.
module gbuf_b_reader
    import gbuf_b_pkg::*;
(
    input  logic                            i_clk,
    input  logic                            i_rstn,
    input  logic                            i_start,
    input  logic                            i_half_sel,
    input  logic [BUF_NUM*BRAM_DATA_WD-1:0] i_bram_rdata,
    output logic                            o_bram_en,
    output logic [BUF_NUM-1:0]              o_bram_cs,
    output logic [ADDR_WIDTH-1:0]           o_bram_addr,
    output logic [OUT_DATA_WD-1:0]          o_data,
    output logic                            o_valid,
    input  logic                            i_ready,
    output logic                            o_busy,
    output logic                            o_done
);

    logic [2:0]              state_q, state_d;
    logic                    half_q, half_d;
    logic [BANK_W-1:0]       bank_q, bank_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic                    rd_all_q, rd_all_d;
    logic                    en_q, en_d;
    logic [BUF_NUM-1:0]      cs_q, cs_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    rvalid_q;
    logic [BANK_W-1:0]       rd_bank_q, rd_bank_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    logic                    rd_half;
    logic [BANK_W-1:0]       rd_bank;
    logic [WORD_W-1:0]       rd_word;
    logic                    issue;
    logic                    ser_load;
    logic                    ser_last;
    logic                    ser_xfer;
    logic [BRAM_DATA_WD-1:0] bank_word;
    logic [BRAM_DATA_WD-1:0] ser_word;

`ifdef GBUF_RD_PREFETCH_EN
    logic [BRAM_DATA_WD-1:0] pf_q, pf_d;
    logic                    pf_valid_q, pf_valid_d;
    logic                    ser_from_pf;
    assign ser_word = ser_from_pf ? pf_q : bank_word;
`else
    assign ser_word = bank_word;
`endif

    // Read data belongs to the bank of the most recent read, one cycle after it was issued.
    assign bank_word = i_bram_rdata[rd_bank_q*BRAM_DATA_WD +: BRAM_DATA_WD];

    assign o_bram_en   = en_q;
    assign o_bram_cs   = cs_q;
    assign o_bram_addr = addr_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

    gbuf_b_lane_ser u_ser (
        .clk     (i_clk),
        .rst_n   (i_rstn),
        .load_i  (ser_load),
        .word_i  (ser_word),
        .ready_i (i_ready),
        .data_o  (o_data),
        .valid_o (o_valid),
        .last_c  (ser_last),
        .xfer_c  (ser_xfer)
    );

    // Next state, read issue and counter advance; {bank,word} always points at the next read.
    always_comb begin
        state_d   = state_q;
        half_d    = half_q;
        bank_d    = bank_q;
        word_d    = word_q;
        rd_all_d  = rd_all_q;
        rd_half   = half_q;
        rd_bank   = bank_q;
        rd_word   = word_q;
        issue     = 1'b0;
        ser_load  = 1'b0;
`ifdef GBUF_RD_PREFETCH_EN
        ser_from_pf = 1'b0;
        pf_d        = pf_q;
        pf_valid_d  = pf_valid_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    rd_half = i_half_sel;
                    rd_bank = '0;
                    rd_word = '0;
                    issue   = 1'b1;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_LAT;
            end
            ST_LAT: begin
                ser_load = 1'b1;
                state_d  = ST_SER;
`ifdef GBUF_RD_PREFETCH_EN
                issue    = !rd_all_q;
`endif
            end
            ST_SER: begin
                if (ser_xfer && ser_last) begin
`ifdef GBUF_RD_PREFETCH_EN
                    if (pf_valid_q) begin
                        ser_load    = 1'b1;
                        ser_from_pf = 1'b1;
                        pf_valid_d  = 1'b0;
                        issue       = !rd_all_q;
                    end else begin
                        state_d = ST_DONE;
                    end
`else
                    if (rd_all_q) begin
                        state_d = ST_DONE;
                    end else begin
                        issue   = 1'b1;
                        state_d = ST_RD;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef GBUF_RD_PREFETCH_EN
        if (rvalid_q && (state_q == ST_SER)) begin
            pf_d       = bank_word;
            pf_valid_d = 1'b1;
        end
`endif

        if (issue) begin
            half_d = rd_half;
            if (rd_word == WORD_W'(WORDS_PER_BANK - 1)) begin
                word_d   = '0;
                bank_d   = rd_bank + BANK_W'(1);
                rd_all_d = (rd_bank == BANK_W'(BUF_NUM - 1));
            end else begin
                word_d   = rd_word + WORD_W'(1);
                bank_d   = rd_bank;
                rd_all_d = 1'b0;
            end
        end

        en_d      = issue;
        cs_d      = issue ? (BUF_NUM'(1) << rd_bank) : '0;
        addr_d    = issue ? {rd_half, rd_word} : '0;
        rd_bank_d = issue ? rd_bank : rd_bank_q;
        busy_d    = (state_d == ST_RD) || (state_d == ST_LAT) || (state_d == ST_SER);
        done_d    = (state_d == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= ST_IDLE;
            half_q    <= 1'b0;
            bank_q    <= '0;
            word_q    <= '0;
            rd_all_q  <= 1'b0;
            en_q      <= 1'b0;
            cs_q      <= '0;
            addr_q    <= '0;
            rvalid_q  <= 1'b0;
            rd_bank_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef GBUF_RD_PREFETCH_EN
            pf_q       <= '0;
            pf_valid_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            half_q    <= half_d;
            bank_q    <= bank_d;
            word_q    <= word_d;
            rd_all_q  <= rd_all_d;
            en_q      <= en_d;
            cs_q      <= cs_d;
            addr_q    <= addr_d;
            rvalid_q  <= en_q;
            rd_bank_q <= rd_bank_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef GBUF_RD_PREFETCH_EN
            pf_q       <= pf_d;
            pf_valid_q <= pf_valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_gbuf_b_reader.sv
// Scoreboard bench for gbuf_b_reader: random BRAM tags, random/forced backpressure, reset and restart.
module tb_gbuf_b_reader;

    localparam int NWORDS = 512;
    localparam int NXFER  = 2048;
`ifdef GBUF_RD_PREFETCH_EN
    localparam int EXP_DONE = 2051;
`else
    localparam int EXP_DONE = 3073;
`endif

    logic          clk;
    logic          i_rstn;
    logic          i_start;
    logic          i_half_sel;
    logic [2047:0] bram_rdata;
    logic          o_bram_en;
    logic [15:0]   o_bram_cs;
    logic [5:0]    o_bram_addr;
    logic [31:0]   o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;
    logic          o_done;

    gbuf_b_reader dut (
        .i_clk        (clk),
        .i_rstn       (i_rstn),
        .i_start      (i_start),
        .i_half_sel   (i_half_sel),
        .i_bram_rdata (bram_rdata),
        .o_bram_en    (o_bram_en),
        .o_bram_cs    (o_bram_cs),
        .o_bram_addr  (o_bram_addr),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    logic [7:0]  seed = 8'h00;
    logic [31:0] q[$];
    int          r_idx, n_xfer, valid_cnt, done_cnt, first_rel, done_rel, stall_cnt;
    int          rmode = 0;
    bit          run_half = 0;
    bit          run_active = 0;
    bit          mon_en = 0;
    bit          stall_active = 0;
    bit          hold_prev = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each lane of a BRAM word is tagged {seed, bank, addr, lane}.
    function automatic logic [127:0] mk(input int k, input logic [5:0] a);
        logic [127:0] w;
        for (int l = 0; l < 4; l++) w[l*32 +: 32] = {seed, 8'(k), 2'b00, a, 8'(l)};
        return w;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: one-cycle latency; unselected banks return junk.
    always @(posedge clk) begin
        for (int k = 0; k < 16; k++)
            bram_rdata[k*128 +: 128] <= (o_bram_en && o_bram_cs[k]) ? mk(k, o_bram_addr)
                                        : {$urandom, $urandom, $urandom, $urandom};
    end

    // Ready driver: always-ready, random, or a 10-cycle stall at bank 5 / word 7 / lane 2.
    initial begin
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                1: i_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (n_xfer == ((5 * 32 + 7) * 4 + 2) && stall_cnt < 10) begin
                        i_ready = 1'b0;
                        stall_active = 1'b1;
                        stall_cnt++;
                    end else begin
                        i_ready = 1'b1;
                        stall_active = 1'b0;
                    end
                end
                default: i_ready = 1'b1;
            endcase
        end
    end

    // Monitor: bus order, scoreboard pops on transfers, hold stability, busy/done.
    initial begin
        int rel;
        forever begin
            @(negedge clk);
            if (mon_en && i_rstn) begin
                rel = cyc - start_cyc + 1;
                if (o_bram_en) begin
                    chk("rd_in_range", 64'(r_idx < NWORDS), 64'(1));
                    chk("rd_cs_addr", 64'({o_bram_cs, o_bram_addr}),
                        64'({16'(1) << (r_idx / 32), run_half, 5'(r_idx % 32)}));
                    r_idx++;
                end else begin
                    chk("idle_bus", 64'({o_bram_cs, o_bram_addr}), 64'(0));
                end
                if (stall_active) chk("stall_no_rd", 64'(o_bram_en), 64'(0));
                if (o_valid) begin
                    valid_cnt++;
                    if (first_rel < 0) first_rel = rel;
                    chk("q_nonempty", 64'(q.size() > 0), 64'(1));
                    if (q.size() > 0) begin
                        if (i_ready) begin
                            chk("data", 64'(o_data), 64'(q.pop_front()));
                            n_xfer++;
                        end else begin
                            chk("data_hold", 64'(o_data), 64'(q[0]));
                        end
                    end
                end
                if (hold_prev) chk("valid_hold", 64'(o_valid), 64'(1));
                hold_prev = o_valid && !i_ready;
                if (run_active && !o_done) chk("busy", 64'(o_busy), 64'(1));
                if (o_done) begin
                    done_cnt++;
                    if (run_active) begin
                        done_rel = rel;
                        chk("done_busy", 64'(o_busy), 64'(0));
                        chk("done_valid", 64'(o_valid), 64'(0));
                        run_active = 0;
                    end
                end
            end
        end
    end

    task automatic run(input bit half, input int mode, input bit poke);
        seed = 8'($urandom);
        q.delete();
        r_idx = 0; n_xfer = 0; valid_cnt = 0; done_cnt = 0;
        first_rel = -1; done_rel = -1; stall_cnt = 0; hold_prev = 0;
        run_half = half;
        rmode = mode;
        for (int b = 0; b < 16; b++)
            for (int w = 0; w < 32; w++)
                for (int l = 0; l < 4; l++)
                    q.push_back({seed, 8'(b), 2'b00, half, 5'(w), 8'(l)});
        @(posedge clk); #1;
        i_half_sel = half;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        i_half_sel = 1'($urandom);
        start_cyc = cyc;
        run_active = 1;
        for (int i = 0; i < 20000 && run_active; i++) begin
            @(posedge clk); #1;
            if (poke && (i == 500 || i == 1700)) begin
                i_start = 1'b1;
                i_half_sel = !half;
            end else begin
                i_start = 1'b0;
            end
        end
        i_start = 1'b0;
        chk("run_finished", 64'(run_active), 64'(0));
        run_active = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("done_count", 64'(done_cnt), 64'(1));
        chk("q_drained", 64'(q.size()), 64'(0));
        chk("reads", 64'(r_idx), 64'(NWORDS));
        chk("xfers", 64'(n_xfer), 64'(NXFER));
        if (mode == 0) begin
            chk("first_valid_cycle", 64'(first_rel), 64'(3));
            chk("done_cycle", 64'(done_rel), 64'(EXP_DONE));
            chk("valid_cycles", 64'(valid_cnt), 64'(NXFER));
        end
        if (mode == 2) chk("stall_len", 64'(stall_cnt), 64'(10));
        rmode = 0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, 64'({o_bram_en, o_bram_cs, o_bram_addr, o_valid, o_busy, o_done}), 64'(0));
        chk({name, "_data"}, 64'(o_data), 64'(0));
    endtask

    initial begin
        i_rstn = 1'b0;
        i_start = 1'b0;
        i_half_sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset_state");
        @(negedge clk);
        i_rstn = 1'b1;
        mon_en = 1;

        run(1'b0, 0, 1'b0);
        run(1'b1, 0, 1'b1);
        run(1'b0, 2, 1'b0);
        run(1'b1, 1, 1'b0);

        // Mid-stream reset, then a fresh run must start again at bank 0.
        mon_en = 0;
        @(posedge clk); #1;
        i_half_sel = 1'b1;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 64'(o_busy), 64'(1));
        i_rstn = 1'b0;
        #1;
        chk_reset_outputs("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("held_reset");
        @(negedge clk);
        i_rstn = 1'b1;
        mon_en = 1;
        run(1'b0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
